// File: rtl/noc_edge_injector_if.sv
// Bundles the host-side sample stream, the switch-side write port and the
// status outputs of the mesh edge injector into one interface.
interface noc_edge_injector_if #(
  parameter int packet_size = 16,
  parameter int xno_switch  = 4,
  parameter int yno_switch  = 4,
  parameter int frame_len   = 784
);
  localparam int XW = $clog2(xno_switch);
  localparam int YW = $clog2(yno_switch);
  localparam int PW = packet_size - XW - YW;
  localparam int CW = (frame_len > 1) ? $clog2(frame_len) : 1;

  logic [PW-1:0]          i_sample;
  logic                   i_sample_valid;
  logic                   o_sample_ready;
  logic                   i_enable;
  logic [packet_size-1:0] o_data;
  logic                   o_wr_valid;
  logic                   i_wr_fifoReady;
  logic [CW-1:0]          o_frame_cnt;
  logic                   o_frame_done;
  logic                   o_overflow;

  // Injector view: consumes host samples and switch readiness, drives the rest.
  modport master (
    input  i_sample, i_sample_valid, i_enable, i_wr_fifoReady,
    output o_sample_ready, o_data, o_wr_valid, o_frame_cnt, o_frame_done, o_overflow
  );

  // Environment view: the host and the switch edge port together.
  modport slave (
    output i_sample, i_sample_valid, i_enable, i_wr_fifoReady,
    input  o_sample_ready, o_data, o_wr_valid, o_frame_cnt, o_frame_done, o_overflow
  );
endinterface

// File: rtl/noc_edge_injector.sv
// Mesh edge injector: buffers host samples in a FIFO, prefixes them with this
// node's X/Y coordinates and writes them into a switch edge port, counting
// delivered packets per frame and flagging host writes made while full.
module noc_edge_injector #(
  parameter int          packet_size = 16,
  parameter int          xno_switch  = 4,
  parameter int          yno_switch  = 4,
  parameter int unsigned x           = 0,
  parameter int unsigned y           = 0,
  parameter int          depth       = 8,
  parameter int          frame_len   = 784
) (
  input logic                clk,
  input logic                i_reset,
  noc_edge_injector_if.master bus
);
  localparam int XW = $clog2(xno_switch);
  localparam int YW = $clog2(yno_switch);
  localparam int PW = packet_size - XW - YW;
  localparam int AW = $clog2(depth);
  localparam int CW = (frame_len > 1) ? $clog2(frame_len) : 1;

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(depth);
  localparam logic [CW-1:0] LAST_CNT   = CW'(frame_len - 1);
  localparam logic [XW-1:0] X_TAG      = XW'(x);
  localparam logic [YW-1:0] Y_TAG      = YW'(y);

  logic [PW-1:0] mem [depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] frame_cnt;
  logic          frame_done;
  logic          overflow;

  logic not_full;
  logic wr_valid;
  logic wr_en;
  logic rd_en;

  // Readiness comes only from the registered fill level, so a full FIFO
  // refuses a write even when a transfer drains an entry on the same edge.
  assign not_full = (count != FULL_COUNT);
  assign wr_valid = bus.i_enable && (count != '0);
  assign wr_en    = bus.i_sample_valid && not_full;
  assign rd_en    = wr_valid && bus.i_wr_fifoReady;

  assign bus.o_sample_ready = not_full;
  assign bus.o_wr_valid     = wr_valid;
  assign bus.o_data         = {X_TAG, Y_TAG, mem[rd_ptr]};
  assign bus.o_frame_cnt    = frame_cnt;
  assign bus.o_frame_done   = frame_done;
  assign bus.o_overflow     = overflow;

  // Sample storage; contents are meaningless after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.i_sample;
    end
  end

  // Pointers and fill level; simultaneous write and transfer leave count alone.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Per-frame delivery counter with a one-cycle pulse after the terminal packet.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (rd_en) begin
      if (frame_cnt == LAST_CNT) begin
        frame_cnt  <= '0;
        frame_done <= 1'b1;
      end else begin
        frame_cnt  <= frame_cnt + 1'b1;
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

  // Sticky flag for a host that offers a sample while the FIFO is full.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      overflow <= 1'b0;
    end else if (bus.i_sample_valid && !not_full) begin
      overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_noc_edge_injector.sv
// Directed, table-driven bench for the mesh edge injector (x=1, y=2, depth 8,
// four packets per frame). Each vector drives inputs just after a falling edge
// and checks the outputs before the next rising edge consumes them.
module tb_noc_edge_injector;
  logic clk;
  logic i_reset;

  int checks;
  int errors;

  noc_edge_injector_if #(
    .packet_size(16), .xno_switch(4), .yno_switch(4), .frame_len(4)
  ) bus ();

  noc_edge_injector #(
    .packet_size(16), .xno_switch(4), .yno_switch(4),
    .x(1), .y(2), .depth(8), .frame_len(4)
  ) dut (
    .clk    (clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  typedef struct {
    bit          do_reset;
    bit          valid;
    logic [11:0] sample;
    bit          en;
    bit          rdy;
    bit          e_wv;
    bit          e_sr;
    bit          chk_data;
    logic [15:0] e_data;
    logic [1:0]  e_fc;
    bit          e_fd;
    bit          e_ov;
  } vec_t;

  vec_t vecs[$];

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic add_vec(input bit rst, input bit valid, input logic [11:0] s,
                         input bit en, input bit rdy, input bit e_wv, input bit e_sr,
                         input bit chk, input logic [15:0] d, input logic [1:0] fc,
                         input bit fd, input bit ov);
    vec_t v;
    v.do_reset = rst;  v.valid = valid; v.sample = s;  v.en = en;     v.rdy = rdy;
    v.e_wv = e_wv;     v.e_sr = e_sr;   v.chk_data = chk; v.e_data = d;
    v.e_fc = fc;       v.e_fd = fd;     v.e_ov = ov;
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input bit e_wv, input bit e_sr,
                              input bit chk, input logic [15:0] d, input logic [1:0] fc,
                              input bit fd, input bit ov);
    compare({tag, ".wr_valid"},     16'(bus.o_wr_valid),     16'(e_wv));
    compare({tag, ".sample_ready"}, 16'(bus.o_sample_ready), 16'(e_sr));
    compare({tag, ".frame_cnt"},    16'(bus.o_frame_cnt),    16'(fc));
    compare({tag, ".frame_done"},   16'(bus.o_frame_done),   16'(fd));
    compare({tag, ".overflow"},     16'(bus.o_overflow),     16'(ov));
    if (chk) begin
      compare({tag, ".data"}, bus.o_data, d);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.i_sample_valid = 1'b0;
    bus.i_wr_fifoReady = 1'b0;
    i_reset = 1'b0;
    #3;
    i_reset = 1'b1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    bus.i_sample_valid = v.valid;
    bus.i_sample       = v.sample;
    bus.i_enable       = v.en;
    bus.i_wr_fifoReady = v.rdy;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_reset = 1'b0;
    bus.i_sample_valid = 1'b0;
    bus.i_sample       = '0;
    bus.i_enable       = 1'b1;
    bus.i_wr_fifoReady = 1'b0;

    // rst valid sample en rdy | wv sr chk data fc fd ov
    // Tag/format: one sample, visible one cycle, then gone.
    add_vec(0, 1, 12'hABC, 1, 1,  0, 1, 0, 16'h0000, 2'd0, 0, 0);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6ABC, 2'd0, 0, 0);
    add_vec(0, 0, 12'h000, 1, 1,  0, 1, 0, 16'h0000, 2'd1, 0, 0);
    // Backpressure: fill with 1..8 while the switch is not ready.
    for (int k = 1; k <= 8; k++) begin
      add_vec(0, 1, 12'(k), 1, 0, (k > 1), 1, (k > 1), 16'h6001, 2'd1, 0, 0);
    end
    add_vec(0, 0, 12'h000, 1, 0,  1, 0, 1, 16'h6001, 2'd1, 0, 0);
    // Overflow attempt while full.
    add_vec(0, 1, 12'h0FF, 1, 0,  1, 0, 1, 16'h6001, 2'd1, 0, 0);
    // Drain 1..8 on consecutive cycles; frame boundaries after 4th and 8th.
    add_vec(0, 0, 12'h000, 1, 1,  1, 0, 1, 16'h6001, 2'd1, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6002, 2'd2, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6003, 2'd3, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6004, 2'd0, 1, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6005, 2'd1, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6006, 2'd2, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6007, 2'd3, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6008, 2'd0, 1, 1);
    add_vec(0, 0, 12'h000, 1, 1,  0, 1, 0, 16'h0000, 2'd1, 0, 1);
    // Simultaneous write/transfer at count 3, then fill and a rejected write when full.
    add_vec(1, 1, 12'h011, 1, 0,  0, 1, 0, 16'h0000, 2'd0, 0, 0);
    add_vec(0, 1, 12'h022, 1, 0,  1, 1, 1, 16'h6011, 2'd0, 0, 0);
    add_vec(0, 1, 12'h033, 1, 0,  1, 1, 1, 16'h6011, 2'd0, 0, 0);
    add_vec(0, 1, 12'h044, 1, 1,  1, 1, 1, 16'h6011, 2'd0, 0, 0);
    add_vec(0, 0, 12'h000, 1, 0,  1, 1, 1, 16'h6022, 2'd1, 0, 0);
    add_vec(0, 1, 12'h055, 1, 0,  1, 1, 1, 16'h6022, 2'd1, 0, 0);
    add_vec(0, 1, 12'h066, 1, 0,  1, 1, 1, 16'h6022, 2'd1, 0, 0);
    add_vec(0, 1, 12'h077, 1, 0,  1, 1, 1, 16'h6022, 2'd1, 0, 0);
    add_vec(0, 1, 12'h088, 1, 0,  1, 1, 1, 16'h6022, 2'd1, 0, 0);
    add_vec(0, 1, 12'h099, 1, 0,  1, 1, 1, 16'h6022, 2'd1, 0, 0);
    add_vec(0, 1, 12'h0AA, 1, 1,  1, 0, 1, 16'h6022, 2'd1, 0, 0);
    add_vec(0, 0, 12'h000, 1, 0,  1, 1, 1, 16'h6033, 2'd2, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6033, 2'd2, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6044, 2'd3, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6055, 2'd0, 1, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6066, 2'd1, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6077, 2'd2, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6088, 2'd3, 0, 1);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6099, 2'd0, 1, 1);
    add_vec(0, 0, 12'h000, 1, 1,  0, 1, 0, 16'h0000, 2'd1, 0, 1);
    // Enable masking: five buffered, three disabled cycles, then two transfers.
    add_vec(1, 1, 12'h101, 1, 0,  0, 1, 0, 16'h0000, 2'd0, 0, 0);
    add_vec(0, 1, 12'h102, 1, 0,  1, 1, 1, 16'h6101, 2'd0, 0, 0);
    add_vec(0, 1, 12'h103, 1, 0,  1, 1, 1, 16'h6101, 2'd0, 0, 0);
    add_vec(0, 1, 12'h104, 1, 0,  1, 1, 1, 16'h6101, 2'd0, 0, 0);
    add_vec(0, 1, 12'h105, 1, 0,  1, 1, 1, 16'h6101, 2'd0, 0, 0);
    add_vec(0, 0, 12'h000, 0, 1,  0, 1, 1, 16'h6101, 2'd0, 0, 0);
    add_vec(0, 0, 12'h000, 0, 1,  0, 1, 1, 16'h6101, 2'd0, 0, 0);
    add_vec(0, 0, 12'h000, 0, 1,  0, 1, 1, 16'h6101, 2'd0, 0, 0);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6101, 2'd0, 0, 0);
    add_vec(0, 0, 12'h000, 1, 1,  1, 1, 1, 16'h6102, 2'd1, 0, 0);

    // Reset state before release.
    #1;
    check_output("reset", 0, 1, 0, 16'h0000, 2'd0, 0, 0);
    #11;
    i_reset = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].do_reset) begin
        pulse_reset();
      end
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i), vecs[i].e_wv, vecs[i].e_sr, vecs[i].chk_data,
                   vecs[i].e_data, vecs[i].e_fc, vecs[i].e_fd, vecs[i].e_ov);
    end

    // Mid-cycle reset with three samples still buffered.
    @(negedge clk);
    bus.i_sample_valid = 1'b0;
    bus.i_enable       = 1'b1;
    bus.i_wr_fifoReady = 1'b1;
    #1;
    check_output("pre_reset", 1, 1, 1, 16'h6103, 2'd2, 0, 0);
    #1;
    i_reset = 1'b0;
    #1;
    check_output("mid_reset", 0, 1, 0, 16'h0000, 2'd0, 0, 0);
    #1;
    i_reset = 1'b1;
    @(negedge clk);
    #1;
    check_output("post_reset", 0, 1, 0, 16'h0000, 2'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_edge_injector.md
# noc_edge_injector

Boundary injection stage for the neural-network mesh. It accepts raw input-layer samples from the host-side stream and buffers them in a FIFO. Each sample is tagged with this injector's source coordinates, and the packets are driven into an edge port of the mesh switch using the switch's write handshake (valid / fifoReady). It also counts delivered packets per frame and pauses or flags on host misuse.

## Interface
- packet_size, 16, full NoC packet width
- xno_switch, 4, mesh columns; header X field = $clog2(xno_switch) bits
- yno_switch, 4, mesh rows; header Y field = $clog2(yno_switch) bits
- x, 2'd0, source X coordinate placed in header
- y, 2'd0, source Y coordinate placed in header
- depth, 8, FIFO entries (power of two, ≥2)
- frame_len, 784, packets per frame (≥1)

- clk  in  1  sole clock, rising edge
- i_reset  in  1  asynchronous, active-low reset (0 = reset)
- i_sample  in  PW  payload, PW = packet_size − $clog2(xno_switch) − $clog2(yno_switch)
- i_sample_valid  in  1  host offers i_sample
- o_sample_ready  out  1  FIFO not full; host write accepted when valid && ready
- i_enable  in  1  injection enable; 0 holds o_wr_valid low (FIFO still fills)
- o_data  out  packet_size  {x, y, payload} to switch i_data_*
- o_wr_valid  out  1  to switch i_wr_valid_*
- i_wr_fifoReady  in  1  from switch o_wr_fifoReady_*
- o_frame_cnt  out  $clog2(frame_len)  packets delivered in current frame
- o_frame_done  out  1  one-cycle pulse after last packet of a frame delivered
- o_overflow  out  1  sticky: host asserted valid while not ready

## Operation
- FIFO: wr_ptr, rd_ptr ($clog2(depth) bits, wrap modulo depth), count (0..depth, $clog2(depth)+1 bits).
- Write: on the edge where i_sample_valid && o_sample_ready, mem[wr_ptr] ← i_sample, wr_ptr++.
- Send: o_wr_valid = i_enable && (count ≠ 0). o_data = {x[XW-1:0], y[YW-1:0], mem[rd_ptr]}. Transfer occurs on an edge with o_wr_valid && i_wr_fifoReady; rd_ptr++.
- count: +1 on write only, −1 on transfer only, unchanged on both or neither.
- o_sample_ready = (count ≠ depth), from registered count only. It never depends combinationally on i_wr_fifoReady. Full with simultaneous transfer still rejects the write that cycle.
- Overflow: i_sample_valid && !o_sample_ready at an edge sets o_overflow. The sample is dropped and the FIFO is unchanged. Only reset clears o_overflow.
- Frame counter: increments per transfer. A transfer at o_frame_cnt = frame_len−1 wraps the counter to 0 and registers o_frame_done = 1 for exactly the next cycle. Otherwise o_frame_done = 0.
- i_enable low does not change counters, pointers or FIFO contents. o_data stays driven. Only o_wr_valid is masked.
- Data order is strictly FIFO. No reordering and no duplication.

## Timing
- Reset (i_reset = 0, async): pointers, count, o_frame_cnt, o_frame_done and o_overflow all go to 0. FIFO contents are discarded. Outputs are o_wr_valid = 0 and o_sample_ready = 1. o_data = {x, y, mem[0]} and its payload is don't-care. Reset mid-frame loses all buffered samples, and the frame count restarts at 0.
- Reset release takes effect at the first rising edge with i_reset = 1. No write or transfer occurs on that edge if i_reset was low during its setup window.
- Latency: a sample written at edge N into an empty FIFO gives o_wr_valid = 1 from edge N (same cycle after the edge), provided i_enable = 1. It can transfer at edge N+1.
- Throughput: one packet per cycle sustained while the host is valid and the switch is ready. The FIFO never goes full in that case.
- o_wr_valid, once high, stays high with o_data stable until transfer, unless i_enable drops.
- o_frame_done is high the cycle after the terminal transfer edge. Back-to-back frames of frame_len = 1 pulse on consecutive cycles.

## Test plan
- Tag/format: x=1, y=2, defaults, i_sample = 12'hABC, switch ready → o_data = 16'h6ABC, with o_wr_valid high one cycle then low.
- Backpressure/full: i_wr_fifoReady = 0, push 8 samples 1..8 → o_sample_ready = 0 after the 8th. Then release ready → outputs 1..8 in order on 8 consecutive cycles. o_sample_ready returns to 1 after the first transfer.
- Overflow: FIFO full, host drives valid with 12'h0FF → o_overflow = 1 and stays 1. The payload 0FF never appears. Reset clears it.
- Simultaneous: count = 3, write and transfer on the same edge → count stays 3 and order is preserved. When full, a write with simultaneous transfer is rejected (count 8 → 7).
- Frame: frame_len = 4, stream 10 packets → o_frame_done pulses after transfers 4 and 8. o_frame_cnt = 2 at the end.
- Enable/reset: 5 buffered, i_enable = 0 for 3 cycles → no transfers and o_wr_valid = 0. Re-enable, transfer 2, then pulse i_reset low mid-cycle → outputs clear immediately and o_sample_ready = 1.
